score_display: RTL and testbench

- Parametrised successor to the four-digit score overlay.
- Converts a binary score to NDIGITS BCD digits with a sequential shift-add-3 engine (no combinational divide/modulo) and holds them in registers.
- Tracks a high score and renders either value as seven-segment digits, with optional leading-zero blanking and overflow saturation.
- Sits between game logic (score counter) and the VGA pixel mux; outputs a pixel-hit flag and colour.

---
 rtl/score_display_pkg.sv | 50 +++++
 rtl/bin2bcd_seq.sv | 97 +++++++++
 rtl/score_display_seg.sv | 47 ++++
 rtl/score_display.sv | 119 +++++++++++
 tb/tb_score_display.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_display_pkg.sv
// Shared constants, types and helpers for the score overlay.
package score_display_pkg;

    // Digit cell geometry in pixels: SEG_W x SEG_H cell, SEG_T thick strokes,
    // middle bar occupying rows SEG_MID .. SEG_MID+SEG_T-1.
    localparam int SEG_W   = 10;
    localparam int SEG_H   = 20;
    localparam int SEG_T   = 2;
    localparam int SEG_MID = 9;

    // Default colours (12-bit RGB 4:4:4).
    localparam logic [11:0] RGB_WHITE  = 12'hfff;
    localparam logic [11:0] RGB_YELLOW = 12'hff0;

    // Conversion engine states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // 10^n, used as the saturation threshold for an n-digit display.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Segment pattern {a,b,c,d,e,f,g} for a BCD digit; non-decimal codes are dark.
    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per cycle.
// Handshake: start is a level request sampled only in IDLE; busy is high from
// LOAD through COMMIT; done is high for exactly the COMMIT cycle, during which
// bcd/sat carry the final result (bcd forced to all 9s when sat is set).
module bin2bcd_seq
    import score_display_pkg::*;
#(
    parameter int W  = 16,
    parameter int ND = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [W-1:0]    bin,
    output logic [4*ND-1:0] bcd,
    output logic            sat,
    output logic            busy,
    output logic            done,
    output state_t          state
);

    // Accumulator carries one guard nibble above the displayed digits.
    localparam int AW = 4 * ND + 4;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [63:0]     SAT_LIM = pow10(ND);
    localparam logic [4*ND-1:0] NINES   = {ND{4'h9}};

    state_t        next_state;
    logic [W-1:0]  sreg;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_adj;
    logic [CW-1:0] cnt;

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (cnt == '0) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Add-3 correction on every nibble that would overflow past 9 when doubled.
    always_comb begin
        acc_adj = acc;
        for (int n = 0; n <= ND; n++) begin
            if (acc[4*n +: 4] >= 4'd5) begin
                acc_adj[4*n +: 4] = acc[4*n +: 4] + 4'd3;
            end
        end
    end

    // Datapath: latch operand in LOAD, shift one bit per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
            acc  <= '0;
            cnt  <= '0;
            sat  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    sreg <= bin;
                    acc  <= '0;
                    cnt  <= CW'(W - 1);
                    // Overflow comes from the binary value, not the guard nibble.
                    sat  <= (64'(bin) >= SAT_LIM);
                end
                SHIFT: begin
                    acc  <= AW'({acc_adj, sreg[W-1]});
                    sreg <= sreg << 1;
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bcd  = sat ? NINES : acc[4*ND-1:0];
    assign busy = (state != IDLE);
    assign done = (state == COMMIT);

endmodule

// File: rtl/score_display_seg.sv
// One seven-segment digit cell: reports whether pixel (x, y) is on a lit stroke.
module score_display_seg
    import score_display_pkg::*;
#(
    parameter int X_ORG = 0,
    parameter int Y_ORG = 0
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [3:0] digit,
    input  logic       blank,
    output logic       hit
);

    localparam logic [10:0] XO = 11'(X_ORG);
    localparam logic [10:0] YO = 11'(Y_ORG);

    logic [10:0] dx;
    logic [10:0] dy;
    logic [6:0]  seg;
    logic        in_cell;
    logic        on_a, on_d, on_g, left, right, upper;

    // Cell-relative coordinates and stroke membership for the current pixel.
    always_comb begin
        dx      = {1'b0, x} - XO;
        dy      = {1'b0, y} - YO;
        in_cell = ({1'b0, x} >= XO) && ({1'b0, y} >= YO)
                  && (dx < 11'(SEG_W)) && (dy < 11'(SEG_H));
        seg     = seg_pattern(digit);
        on_a    = (dy < 11'(SEG_T));
        on_d    = (dy >= 11'(SEG_H - SEG_T));
        on_g    = (dy >= 11'(SEG_MID)) && (dy < 11'(SEG_MID + SEG_T));
        left    = (dx < 11'(SEG_T));
        right   = (dx >= 11'(SEG_W - SEG_T));
        upper   = (dy < 11'(SEG_H / 2));
        hit     = !blank && in_cell &&
                  ((seg[6] && on_a) ||
                   (seg[5] && right && upper) ||
                   (seg[4] && right && !upper) ||
                   (seg[3] && on_d) ||
                   (seg[2] && left && !upper) ||
                   (seg[1] && left && upper) ||
                   (seg[0] && on_g));
    end

endmodule

// File: rtl/score_display.sv
// Score overlay: converts the game score to BCD, tracks the high score and
// draws either value as a row of seven-segment digits.
module score_display
    import score_display_pkg::*;
#(
    parameter int          SCORE_W  = 16,
    parameter int          NDIGITS  = 4,
    parameter int          X0       = 565,
    parameter int          Y0       = 20,
    parameter int          PITCH    = 15,
    parameter int          BLANK_LZ = 1,
    parameter logic [11:0] RGB_CUR  = RGB_WHITE,
    parameter logic [11:0] RGB_HI   = RGB_YELLOW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic [SCORE_W-1:0] score,
    input  logic               show_hi,
    input  logic               clr_hi,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic               isScore,
    output logic [11:0]        score_rgb
);

    localparam int DW = 4 * NDIGITS;

    logic [SCORE_W-1:0] last_conv;
    logic [SCORE_W-1:0] hi_bin;
    logic [DW-1:0]      cur_digits;
    logic [DW-1:0]      hi_digits;
    logic [DW-1:0]      shown;
    logic [DW-1:0]      eng_bcd;
    logic               eng_sat;
    logic               eng_done;
    state_t             eng_state;
    logic [NDIGITS-1:0] blank;
    logic [NDIGITS-1:0] hits;
    logic               lead_zero;

    // A new conversion is requested whenever the score differs from the last
    // value loaded; changes during a conversion are picked up on return to IDLE.
    bin2bcd_seq #(
        .W  (SCORE_W),
        .ND (NDIGITS)
    ) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (score != last_conv),
        .bin   (score),
        .bcd   (eng_bcd),
        .sat   (eng_sat),
        .busy  (busy),
        .done  (eng_done),
        .state (eng_state)
    );

    // Commit digits, overflow and high score; clr_hi clears first, and a
    // simultaneous commit is then compared against the cleared value.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_conv  <= '0;
            hi_bin     <= '0;
            cur_digits <= '0;
            hi_digits  <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= eng_done;
            if (eng_state == LOAD) begin
                last_conv <= score;
            end
            if (eng_done) begin
                cur_digits <= eng_bcd;
                overflow   <= eng_sat;
            end
            if (clr_hi) begin
                hi_bin    <= '0;
                hi_digits <= '0;
            end
            if (eng_done && (last_conv > (clr_hi ? {SCORE_W{1'b0}} : hi_bin))) begin
                hi_bin    <= last_conv;
                hi_digits <= eng_bcd;
            end
        end
    end

    // Pick the displayed value and blank leading zeros (the last digit always shows).
    always_comb begin
        shown     = show_hi ? hi_digits : cur_digits;
        lead_zero = 1'b1;
        blank     = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            lead_zero = lead_zero && (shown[4*(NDIGITS-1-i) +: 4] == 4'd0);
            blank[i]  = (BLANK_LZ != 0) && lead_zero && (i != NDIGITS - 1);
        end
    end

    // Digit i = 0 is the most significant and sits leftmost.
    for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
        score_display_seg #(
            .X_ORG (X0 + g * PITCH),
            .Y_ORG (Y0)
        ) u_seg (
            .x     (x),
            .y     (y),
            .digit (shown[4*(NDIGITS-1-g) +: 4]),
            .blank (blank[g]),
            .hit   (hits[g])
        );
    end

    assign isScore   = |hits;
    assign score_rgb = show_hi ? RGB_HI : RGB_CUR;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with default parameters.
module tb_score_display;

    localparam int SCORE_W = 16;
    localparam int X0      = 565;
    localparam int Y0      = 20;
    localparam int PITCH   = 15;

    logic               clk = 1'b0;
    logic               reset;
    logic [9:0]         x;
    logic [9:0]         y;
    logic [SCORE_W-1:0] score;
    logic               show_hi;
    logic               clr_hi;
    logic               busy;
    logic               done;
    logic               overflow;
    logic               isScore;
    logic [11:0]        score_rgb;

    int n_checks = 0;
    int n_fail   = 0;

    score_display #(
        .SCORE_W  (SCORE_W),
        .NDIGITS  (4),
        .X0       (X0),
        .Y0       (Y0),
        .PITCH    (PITCH),
        .BLANK_LZ (1),
        .RGB_CUR  (12'hfff),
        .RGB_HI   (12'hff0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .score     (score),
        .show_hi   (show_hi),
        .clr_hi    (clr_hi),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .isScore   (isScore),
        .score_rgb (score_rgb)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference seven-segment table {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // Move the pixel to (digit, dx, dy) and check isScore.
    task automatic probe(input string tag, input int digit, input int sx, input int sy, input logic exp);
        @(negedge clk);
        x = 10'(X0 + digit * PITCH + sx);
        y = 10'(Y0 + sy);
        #2;
        check(tag, 32'(isScore), 32'(exp));
    endtask

    // Probe one pixel inside every stroke of every digit, plus a dark interior pixel.
    task automatic check_display(input string tag, input logic [15:0] digs);
        int px[7];
        int py[7];
        logic lead;
        logic vis;
        logic [3:0] d;
        logic [6:0] p;
        px = '{5, 9, 9, 5, 0, 0, 5};
        py = '{0, 5, 15, 19, 15, 5, 9};
        lead = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d    = digs[4*(3-i) +: 4];
            lead = lead && (d == 4'd0);
            vis  = !(lead && i != 3);
            p    = seg_ref(d);
            for (int s = 0; s < 7; s++) begin
                probe($sformatf("%s d%0d s%0d", tag, i, s), i, px[s], py[s], vis && p[6-s]);
            end
        end
        probe($sformatf("%s interior", tag), 3, 4, 5, 1'b0);
    endtask

    // Drive a score and expect done exactly SCORE_W+2 edges after the sampling edge.
    task automatic convert(input string tag, input logic [15:0] val, input logic pulse_clr);
        int lat;
        @(negedge clk);
        reset = 1'b0;
        score = val;
        @(posedge clk);
        lat = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) check({tag, " busy"}, 32'(busy), 32'd1);
            if (done) break;
            if (lat == 17 && pulse_clr) clr_hi = 1'b1;
        end
        clr_hi = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(SCORE_W + 2));
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_clr_hi();
        @(negedge clk);
        clr_hi = 1'b1;
        @(negedge clk);
        clr_hi = 1'b0;
    endtask

    initial begin
        int pulses;
        reset   = 1'b1;
        score   = '0;
        x       = '0;
        y       = '0;
        show_hi = 1'b0;
        clr_hi  = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("zero held busy", 32'(busy), 32'd0);
        end
        check_display("rst cur", 16'h0000);
        show_hi = 1'b1;
        check_display("rst hi", 16'h0000);
        show_hi = 1'b0;

        // Plain conversion.
        convert("1234", 16'd1234, 1'b0);
        check("1234 overflow", 32'(overflow), 32'd0);
        check_display("1234 cur", 16'h1234);
        check("cur rgb", 32'(score_rgb), 32'h0fff);
        show_hi = 1'b1;
        check_display("1234 hi", 16'h1234);
        check("hi rgb", 32'(score_rgb), 32'h0ff0);
        show_hi = 1'b0;

        // Saturation and recovery.
        convert("10000", 16'd10000, 1'b0);
        check("10000 overflow", 32'(overflow), 32'd1);
        check_display("10000 cur", 16'h9999);
        convert("42", 16'd42, 1'b0);
        check("42 overflow", 32'(overflow), 32'd0);
        check_display("42 cur", 16'h0042);
        show_hi = 1'b1;
        check_display("sat hi", 16'h9999);

        // High score tracking and clearing.
        pulse_clr_hi();
        check_display("clr hi", 16'h0000);
        show_hi = 1'b0;
        convert("900", 16'd900, 1'b0);
        convert("300", 16'd300, 1'b0);
        check_display("300 cur", 16'h0300);
        show_hi = 1'b1;
        check_display("900 hi", 16'h0900);
        check("900 hi rgb", 32'(score_rgb), 32'h0ff0);
        pulse_clr_hi();
        check_display("clr hi 2", 16'h0000);
        show_hi = 1'b0;
        convert("950", 16'd950, 1'b0);
        convert("300 clr commit", 16'd300, 1'b1);
        show_hi = 1'b1;
        check_display("clr commit hi", 16'h0300);
        show_hi = 1'b0;

        // Rapid changes 5 -> 6 -> 7: 5 is latched, then 7 follows.
        x = 10'(X0 + 3 * PITCH + 0);
        y = 10'(Y0 + 5);
        @(negedge clk);
        score = 16'd5;
        @(negedge clk);
        @(negedge clk);
        score = 16'd6;
        @(negedge clk);
        score = 16'd7;
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    check("step first f", 32'(isScore), 32'd1);
                    y = 10'(Y0 + 15);
                    #1;
                    check("step first e", 32'(isScore), 32'd0);
                    y = 10'(Y0 + 5);
                end
            end
        end
        check("step done count", 32'(pulses), 32'd2);
        check_display("step final", 16'h0007);

        // Reset in the middle of a conversion of 555.
        @(negedge clk);
        score = 16'd555;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("555 busy", 32'(busy), 32'd1);
            check("555 no done", 32'(done), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        x = 10'(X0 + 3 * PITCH + 0);
        y = 10'(Y0 + 5);
        @(posedge clk);
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort digit0 f", 32'(isScore), 32'd1);
        convert("555 after reset", 16'd555, 1'b0);
        check_display("555 cur", 16'h0555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
